// File: rtl/rn_struct_loader.sv
`timescale 1ns/1ps
// rn_struct_loader: streams network layer descriptors from a synchronous memory
// and presents the current layer header, one KxK kernel and the filter bias to
// the conv datapath. Optional header sanity checking is enabled by defining
// RN_STRUCT_CHECK_EN, which adds the cfg_err port and an ERR state.
//
// Handshake: next / next_filter / next_channel are single-cycle pulses. A pulse
// is accepted only while struct_ready is high (next is also accepted in IDLE).
// On acceptance struct_ready drops the following cycle and rises again when the
// last requested word has been captured. Pulses seen while busy are dropped.
module rn_struct_loader #(
  parameter int DW   = 8,
  parameter int AW   = 16,
  parameter int KMAX = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_rd,
  output logic [AW-1:0]          mem_addr,
  input  logic [DW-1:0]          mem_rdata,
  input  logic                   next,
  input  logic                   next_filter,
  input  logic                   next_channel,
  output logic                   struct_ready,
  output logic [DW-1:0]          last_stage,
  output logic [DW-1:0]          amount_channels,
  output logic [DW-1:0]          kernel_size,
  output logic [DW-1:0]          stride,
  output logic [DW-1:0]          if_size,
  output logic [DW-1:0]          kernel_size_2,
  output logic [2*DW-1:0]        ifsize_2,
  output logic [DW-1:0]          amount_filters,
  output logic [DW-1:0]          of_size,
  output logic [DW-1:0]          ofsize_2,
  output logic [DW-1:0]          of_offset,
  output logic [KMAX*KMAX*DW-1:0] kernel,
  output logic [DW-1:0]          bias,
  output logic                   chan_last,
  output logic                   filt_last
`ifdef RN_STRUCT_CHECK_EN
  ,
  output logic                   cfg_err
`endif
);

  localparam int NTAP = KMAX * KMAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BIAS,
    S_KERN,
    S_READY
`ifdef RN_STRUCT_CHECK_EN
    ,
    S_ERR
`endif
  } state_t;

  // Tag travelling with each read so the returning word lands in the right field.
  typedef enum logic [1:0] {C_HDR, C_BIAS, C_KERN} cap_t;

  state_t          state, state_n;
  logic [DW-1:0]   cnt, cnt_n;       // reads issued within the current phase
  logic [AW-1:0]   ptr, ptr_n;       // address of the next word to read
  logic [AW-1:0]   base, base_n;     // start address of the current layer
  logic [DW-1:0]   filt, filt_n;
  logic [DW-1:0]   chan, chan_n;

  logic            rd_d;
  cap_t            cap_kind;
  logic [DW-1:0]   cap_idx;

  logic [AW-1:0]   filt_len;
  logic [AW-1:0]   layer_len;
  logic [AW-1:0]   next_base;
  logic [AW-1:0]   filt_addr;
  logic            kern_done;
  logic            check_fail;

  // Layer geometry, all in AW-bit modular arithmetic.
  assign filt_len  = AW'(1) + AW'(amount_channels) * AW'(kernel_size_2);
  assign layer_len = AW'(12) + AW'(amount_filters) * filt_len;
  assign next_base = (last_stage == DW'(1)) ? '0 : base + layer_len;
  assign filt_addr = base + AW'(12) + (AW'(filt) + AW'(1)) * filt_len;
  assign kern_done = (state == S_KERN) && (cnt == kernel_size_2);
  assign chan_last = (chan == amount_channels - DW'(1));
  assign filt_last = (filt == amount_filters - DW'(1));

`ifdef RN_STRUCT_CHECK_EN
  logic [2*DW-1:0] ks_sq;
  assign ks_sq = (2*DW)'(kernel_size) * (2*DW)'(kernel_size);
  assign check_fail = (kernel_size == '0) || (int'(kernel_size) > KMAX) ||
                      (stride == '0) || (amount_channels == '0) ||
                      (amount_filters == '0) || ((2*DW)'(kernel_size_2) != ks_sq);
  assign cfg_err = (state == S_ERR);
`else
  assign check_fail = 1'b0;
`endif

  // State, address pointer and filter/channel position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      base  <= '0;
      filt  <= '0;
      chan  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      base  <= base_n;
      filt  <= filt_n;
      chan  <= chan_n;
    end
  end

  // Next-state, command acceptance and read-strobe generation.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    ptr_n        = ptr;
    base_n       = base;
    filt_n       = filt;
    chan_n       = chan;
    mem_rd       = 1'b0;
    mem_addr     = ptr;
    struct_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (next) begin
          state_n = S_HDR;
          cnt_n   = '0;
          ptr_n   = base;
          filt_n  = '0;
          chan_n  = '0;
        end
      end
      S_HDR: begin
        mem_rd = 1'b1;
        ptr_n  = ptr + AW'(1);
        cnt_n  = cnt + DW'(1);
        if (cnt == DW'(11)) begin
          cnt_n = '0;
`ifdef RN_STRUCT_CHECK_EN
          state_n = check_fail ? S_ERR : S_BIAS;
`else
          state_n = S_BIAS;
`endif
        end
      end
      S_BIAS: begin
        mem_rd  = 1'b1;
        ptr_n   = ptr + AW'(1);
        cnt_n   = '0;
        state_n = S_KERN;
      end
      S_KERN: begin
        if (cnt != kernel_size_2) begin
          mem_rd = 1'b1;
          ptr_n  = ptr + AW'(1);
          cnt_n  = cnt + DW'(1);
        end else begin
          // Last word returns this cycle and is captured at the edge below.
          state_n = S_READY;
        end
      end
      S_READY: begin
        struct_ready = 1'b1;
        if (next) begin
          state_n = S_HDR;
          cnt_n   = '0;
          base_n  = next_base;
          ptr_n   = next_base;
          filt_n  = '0;
          chan_n  = '0;
        end else if (next_filter) begin
          if (!filt_last) begin
            state_n = S_BIAS;
            ptr_n   = filt_addr;
            filt_n  = filt + DW'(1);
            chan_n  = '0;
          end
        end else if (next_channel) begin
          if (!chan_last) begin
            // ptr already sits on the first word of the next channel kernel.
            state_n = S_KERN;
            cnt_n   = '0;
            chan_n  = chan + DW'(1);
          end
        end
      end
      default: begin
        state_n = state;
      end
    endcase
  end

  // Capture returning words one cycle after their read strobe; clear unused taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d            <= 1'b0;
      cap_kind        <= C_HDR;
      cap_idx         <= '0;
      last_stage      <= '0;
      amount_channels <= '0;
      kernel_size     <= '0;
      stride          <= '0;
      if_size         <= '0;
      kernel_size_2   <= '0;
      ifsize_2        <= '0;
      amount_filters  <= '0;
      of_size         <= '0;
      ofsize_2        <= '0;
      of_offset       <= '0;
      kernel          <= '0;
      bias            <= '0;
    end else begin
      rd_d     <= mem_rd;
      cap_idx  <= cnt;
      cap_kind <= (state == S_HDR) ? C_HDR : ((state == S_BIAS) ? C_BIAS : C_KERN);
      if (rd_d && cap_kind == C_HDR) begin
        case (int'(cap_idx))
          0:       last_stage          <= mem_rdata;
          1:       amount_channels     <= mem_rdata;
          2:       kernel_size         <= mem_rdata;
          3:       stride              <= mem_rdata;
          4:       if_size             <= mem_rdata;
          5:       kernel_size_2       <= mem_rdata;
          6:       ifsize_2[DW-1:0]    <= mem_rdata;
          7:       ifsize_2[2*DW-1:DW] <= mem_rdata;
          8:       amount_filters      <= mem_rdata;
          9:       of_size             <= mem_rdata;
          10:      ofsize_2            <= mem_rdata;
          11:      of_offset           <= mem_rdata;
          default: ;
        endcase
      end
      if (rd_d && cap_kind == C_BIAS) begin
        bias <= mem_rdata;
      end
      for (int j = 0; j < NTAP; j++) begin
        if (rd_d && cap_kind == C_KERN && int'(cap_idx) == j) begin
          kernel[j*DW +: DW] <= mem_rdata;
        end else if (kern_done && j >= int'(kernel_size_2)) begin
          kernel[j*DW +: DW] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rn_struct_loader.sv
`timescale 1ns/1ps
// Self-checking bench for rn_struct_loader: a memory model, a command driver
// with a behavioural reference model, and a negedge monitor that checks read
// addresses and every struct_ready rising edge against expected queues.
module tb_rn_struct_loader;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int KMAX = 3;
  localparam int NT = KMAX * KMAX;
  localparam int RW = 32 + 12 * DW + NT * DW + DW + 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic next = 1'b0, next_filter = 1'b0, next_channel = 1'b0;
  logic struct_ready;
  logic [DW-1:0] last_stage, amount_channels, kernel_size, stride, if_size, kernel_size_2;
  logic [2*DW-1:0] ifsize_2;
  logic [DW-1:0] amount_filters, of_size, ofsize_2, of_offset;
  logic [NT*DW-1:0] kernel;
  logic [DW-1:0] bias;
  logic chan_last, filt_last;
`ifdef RN_STRUCT_CHECK_EN
  logic cfg_err;
`endif

  always #5 clk = ~clk;

  rn_struct_loader #(.DW(DW), .AW(AW), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .next(next), .next_filter(next_filter), .next_channel(next_channel),
    .struct_ready(struct_ready), .last_stage(last_stage), .amount_channels(amount_channels),
    .kernel_size(kernel_size), .stride(stride), .if_size(if_size),
    .kernel_size_2(kernel_size_2), .ifsize_2(ifsize_2), .amount_filters(amount_filters),
    .of_size(of_size), .ofsize_2(ofsize_2), .of_offset(of_offset), .kernel(kernel),
    .bias(bias), .chan_last(chan_last), .filt_last(filt_last)
`ifdef RN_STRUCT_CHECK_EN
    , .cfg_err(cfg_err)
`endif
  );

  // Synchronous memory: data valid the cycle after the strobe.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_addr_q[$];
  logic [RW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] mrd(int a);
    return mem[16'(a)];
  endfunction

  // Expected presented state for the model's current (base, filter, channel).
  int m_state = 0;  // 0 idle, 1 ready, 2 busy
  int m_base = 0, m_filt = 0, m_chan = 0;

  function automatic logic [RW-1:0] model_rec(int t);
    logic [DW-1:0] h[12];
    logic [NT*DW-1:0] kv;
    int ac, ks2, af, fs, ka;
    for (int i = 0; i < 12; i++) h[i] = mrd(m_base + i);
    ac = h[1]; ks2 = h[5]; af = h[8];
    fs = m_base + 12 + m_filt * (1 + ac * ks2);
    ka = fs + 1 + m_chan * ks2;
    kv = '0;
    for (int i = 0; i < NT; i++) if (i < ks2) kv[i*DW +: DW] = mrd(ka + i);
    return {32'(t), h[0], h[1], h[2], h[3], h[4], h[5], h[7], h[6], h[8], h[9], h[10], h[11],
            kv, mrd(fs), (m_chan == ac - 1), (m_filt == af - 1)};
  endfunction

  function automatic logic [RW-1:0] observed(int t);
    return {32'(t), last_stage, amount_channels, kernel_size, stride, if_size, kernel_size_2,
            ifsize_2, amount_filters, of_size, ofsize_2, of_offset, kernel, bias,
            chan_last, filt_last};
  endfunction

  // Monitor: every read strobe and every struct_ready rise is checked.
  logic prev_ready = 1'b0;
  logic [AW-1:0] mon_a;
  logic [RW-1:0] mon_e, mon_o;
  always @(negedge clk) begin
    if (mem_rd) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL read_addr: got unexpected read at %h, required no read", mem_addr);
      end else begin
        mon_a = exp_addr_q.pop_front();
        if (mem_addr !== mon_a) begin
          errors++;
          $display("FAIL read_addr: got %h required %h", mem_addr, mon_a);
        end
      end
    end
    if (struct_ready && !prev_ready) begin
      checks++;
      mon_o = observed(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ready_rise: unexpected ready at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_o !== mon_e) begin
          errors++;
          $display("FAIL struct: got %h required %h", mon_o, mon_e);
        end
      end
    end
    prev_ready = struct_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic set_layer(input int b, input int last, input int ac, input int ks,
                           input int af, input int st);
    mem[16'(b + 0)] = 8'(last);
    mem[16'(b + 1)] = 8'(ac);
    mem[16'(b + 2)] = 8'(ks);
    mem[16'(b + 3)] = 8'(st);
    mem[16'(b + 5)] = 8'(ks * ks);
    mem[16'(b + 8)] = 8'(af);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (struct_ready !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (struct_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: got ready=%b required 1 within 500 cycles", struct_ready);
    end else begin
      m_state = 1;
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({mem_rd, mem_addr, struct_ready, observed(0)} !== '0) begin
      errors++;
      $display("FAIL %s: got rd=%b addr=%h rdy=%b state=%h required all 0", name, mem_rd,
               mem_addr, struct_ready, observed(0));
    end
`ifdef RN_STRUCT_CHECK_EN
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_cfg_err: got %b required 0", name, cfg_err);
    end
`endif
  endtask

  // Issue a command pulse; the model decides acceptance and queues the expectations.
  task automatic issue(input bit n, input bit f, input bit c, input bit do_wait);
    int t, ac, ks2, af, fs, first, num;
    bit acc;
    @(negedge clk);
    next = n; next_filter = f; next_channel = c;
    t = cyc + 1;
    acc = 0;
    if (m_state == 0 && n) begin
      acc = 1; m_base = 0; m_filt = 0; m_chan = 0;
    end else if (m_state == 1) begin
      ac = mrd(m_base + 1); ks2 = mrd(m_base + 5); af = mrd(m_base + 8);
      if (n) begin
        acc = 1;
        m_base = (mrd(m_base) == 1) ? 0 : ((m_base + 12 + af * (1 + ac * ks2)) & 16'hFFFF);
        m_filt = 0; m_chan = 0;
      end else if (f) begin
        if (m_filt != af - 1) begin acc = 1; m_filt++; m_chan = 0; end
      end else if (c) begin
        if (m_chan != ac - 1) begin acc = 1; m_chan++; end
      end
    end
    if (acc) begin
      ac = mrd(m_base + 1); ks2 = mrd(m_base + 5);
      fs = m_base + 12 + m_filt * (1 + ac * ks2);
      if (n) begin first = m_base; num = 13 + ks2; end
      else if (f) begin first = fs; num = 1 + ks2; end
      else begin first = fs + 1 + m_chan * ks2; num = ks2; end
      for (int i = 0; i < num; i++) exp_addr_q.push_back(16'(first + i));
      exp_q.push_back(model_rec(t + num + 1));
      m_state = 2;
    end
    @(negedge clk);
    next = 0; next_filter = 0; next_channel = 0;
    if (acc && do_wait) begin
      wait_ready();
    end else if (!acc) begin
      repeat (3) @(negedge clk);
      checks++;
      if (struct_ready !== (m_state == 1)) begin
        errors++;
        $display("FAIL ignored_cmd: got ready=%b required %b", struct_ready, (m_state == 1));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_zero("reset_now");
    rst = 0;
    exp_addr_q.delete();
    exp_q.delete();
    m_state = 0; m_base = 0; m_filt = 0; m_chan = 0;
    @(negedge clk);
    check_zero("reset_after");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    set_layer(0, 0, 2, 3, 2, 1);                  // L = 50
    set_layer(50, 0, 3, 2, 2, 2);                 // L = 38
    set_layer(88, 1, $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
              $urandom_range(1, 4));

    repeat (3) @(negedge clk);
    check_zero("reset_init");
    rst = 0;

    issue(0, 1, 0, 1);        // next_filter in IDLE: ignored
    issue(0, 0, 1, 1);        // next_channel in IDLE: ignored
    issue(1, 0, 0, 0);        // layer 0: reads 0..21
    repeat (2) @(negedge clk);
    issue(0, 0, 1, 0);        // busy: ignored
    issue(1, 0, 0, 0);        // busy: ignored
    wait_ready();
    issue(0, 0, 1, 1);        // channel 1: reads 22..30
    issue(0, 0, 1, 1);        // chan_last: ignored
    issue(0, 1, 0, 1);        // filter 1: reads 31..40
    issue(0, 1, 0, 1);        // filt_last: ignored
    issue(1, 0, 1, 1);        // next wins: layer at 50, ks=2
    issue(1, 0, 0, 1);        // layer at 88, last_stage=1
    issue(1, 0, 0, 1);        // wraps to address 0

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) issue(1, 0, 0, 1);
      else if (r < 5) issue(0, 1, 0, 1);
      else if (r < 9) issue(0, 0, 1, 1);
      else issue(0, 1, 1, 1);
    end

    issue(1, 0, 0, 0);        // start a header burst, then reset mid-burst
    repeat (4) @(negedge clk);
    do_reset();
    issue(1, 0, 0, 1);        // first next after reset loads from 0

`ifdef RN_STRUCT_CHECK_EN
    do_reset();
    mem[3] = 8'd0;            // stride 0 in layer 0 header
    @(negedge clk);
    next = 1;
    for (int i = 0; i < 12; i++) exp_addr_q.push_back(16'(i));
    @(negedge clk);
    next = 0;
    repeat (20) @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1 || struct_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_set: got err=%b rdy=%b required err=1 rdy=0", cfg_err, struct_ready);
    end
    @(negedge clk);
    next = 1;
    @(negedge clk);
    next = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1 || struct_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_hold: got err=%b rdy=%b required err=1 rdy=0", cfg_err, struct_ready);
    end
`endif

    repeat (5) @(negedge clk);
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL addr_queue_drain: got %0d pending required 0", exp_addr_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ready_queue_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
